fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL use one clock and one reset: the clock is clk, and reset is rst, asynchronous and active-high.
REQ-002 SHALL expose these ports:
- clk  in  1  clock
- rst  in  1  async active-high reset
- StallF  in  1  hazard stall, fetch
- StallD  in  1  hazard stall, decode
- PCSrcD  in  1  taken branch resolved in D
- JumpD  in  1  jump in D
- PCBranchD  in  32  branch target
- PCJumpD  in  32  jump target
- imem_req  out  1  instruction memory request
- imem_addr  out  32  request address
- imem_ack  in  1  response valid, may be the same cycle as imem_req
- imem_rdata  in  32  instruction word
- InstrD  out  32  IF/ID instruction
- PCPlus4D  out  32  IF/ID PC+4
- ValidD  out  1  IF/ID holds a real instruction
- FetchStall  out  1  fetch is waiting on memory; the hazard unit ORs it into StallF/StallD
REQ-003 SHALL use these parameters:
- RESET_PC, default 32'h0000_0000, first fetch address
- NOP, default 32'h0000_0000, bubble encoding

Function
REQ-004 SHALL define stall = StallF | StallD, so the two stall inputs are never honoured separately.
REQ-005 SHALL define redirect = (PCSrcD | JumpD) & ValidD & !stall; if PCSrcD and JumpD are both set, PCSrcD has priority and the target is PCBranchD.
REQ-006 SHALL use a bubble in IF/ID defined as InstrD=NOP, ValidD=0, PCPlus4D unchanged.
REQ-007 SHALL implement an FSM with three states: FETCH, HOLD and DRAIN.
REQ-008 In FETCH, the block SHALL drive imem_req=1 and imem_addr=PCF:
- ack & redirect: PCF<=target; IF/ID<=bubble; stay in FETCH; the acked word is discarded.
- !ack & redirect: PCF<=target; IF/ID<=bubble; latch PCF into drain_addr; go to DRAIN.
- ack & !stall: IF/ID<={imem_rdata, PCF+4, 1}; PCF<=PCF+4.
- ack & stall: buf<=imem_rdata; go to HOLD; IF/ID and PCF are held.
- !ack & !stall: IF/ID<=bubble.
- !ack & stall: everything is held.
REQ-009 In HOLD, the block SHALL drive imem_req=0:
- redirect: discard buf; PCF<=target; IF/ID<=bubble; go to FETCH.
- !stall: IF/ID<={buf, PCF+4, 1}; PCF<=PCF+4; go to FETCH.
- stall: stay in HOLD.
REQ-010 In DRAIN, the block SHALL drive imem_req=1 and imem_addr=drain_addr, and SHALL ignore redirects:
- each cycle with !stall: IF/ID<=bubble.
- on ack: discard imem_rdata; go to FETCH, where PCF already equals the target.
REQ-011 SHALL drive FetchStall = imem_req & !imem_ack, combinationally.
REQ-012 SHALL hold imem_addr stable while imem_req=1 and imem_ack=0, and SHALL never drop imem_req before imem_ack (no request abort).
REQ-013 SHALL compute PC+4 modulo 2^32, so that 32'hFFFF_FFFC wraps to 0.
REQ-014 SHALL give stall priority over redirect and redirect priority over sequential fetch.
REQ-015 SHALL have a fetch-to-IF/ID latency of 1 cycle after the ack cycle when no stall is applied.

Reset
REQ-016 While rst=1, the block SHALL hold PCF=RESET_PC, state=FETCH, buf=0, drain_addr=0, InstrD=NOP, PCPlus4D=0, ValidD=0, and imem_req=0 (gated combinationally by rst).
REQ-017 On a reset during an outstanding request or in DRAIN, any later imem_ack for the old request SHALL be the memory's responsibility; the block restarts a fetch at RESET_PC in the first cycle after rst falls.

Structure
REQ-018 SHALL place RESET_PC, NOP and the FETCH/HOLD/DRAIN state encoding in the shared pipeline package.
REQ-019 SHALL implement the IF/ID register as the sub-module if_id_reg, with load, bubble and hold controls; PCF, the FSM, buf and drain_addr stay in fetch_stage.

Verification
REQ-020 Zero-wait sequential fetch: ack always 1, no stalls -> imem_addr 0,4,8,...; ValidD=1 from cycle 2; PCPlus4D tracks imem_addr+4.
REQ-021 Wait states: ack delayed 2 cycles at addr 0x8 -> FetchStall=1 for 2 cycles; imem_addr held at 0x8; two bubbles enter IF/ID; the word then loads with PCPlus4D=0xC.
REQ-022 Ack under stall: StallF=StallD=1 in the ack cycle for 0x10, held 3 cycles -> HOLD; imem_req=0; on release InstrD=that word, PCPlus4D=0x14, and imem_addr is next 0x14 with no refetch of 0x10.
REQ-023 Redirect with outstanding miss: PCSrcD=1, ValidD=1, PCBranchD=0x100 while 0x20 is unacked -> DRAIN; imem_addr stays 0x20 until ack; that word is discarded; the next request is 0x100.
REQ-024 Simultaneous PCSrcD and JumpD, PCBranchD=0x40, PCJumpD=0x80 -> next fetch is 0x40; IF/ID is bubbled for one cycle.
REQ-025 Mid-operation reset: rst asserted in DRAIN -> imem_req=0 immediately and ValidD=0; after release, the first imem_addr is RESET_PC.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared pipeline constants, fetch FSM encoding and PC helper
package fetch_stage_pkg;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam logic [31:0] NOP_DEF      = 32'h0000_0000;
   localparam logic [1:0]  FETCH        = 2'd0;
   localparam logic [1:0]  HOLD         = 2'd1;
   localparam logic [1:0]  DRAIN        = 2'd2;
   function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction
endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register with load, bubble and hold controls
module if_id_reg
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] NOP = NOP_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_load,
   input  logic        i_bubble,
   input  logic [31:0] i_instr,
   input  logic [31:0] i_pc_plus4,
   output logic [31:0] o_instr,
   output logic [31:0] o_pc_plus4,
   output logic        o_valid
);
   logic [31:0] r_instr, r_pc_plus4;
   logic        r_valid;
   assign o_instr    = r_instr;
   assign o_pc_plus4 = r_pc_plus4;
   assign o_valid    = r_valid;
   // bubble beats load and keeps PC+4; with neither asserted the register holds
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_instr    <= NOP;
         r_pc_plus4 <= '0;
         r_valid    <= 1'b0;
      end else if (i_bubble) begin
         r_instr <= NOP;
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_instr    <= i_instr;
         r_pc_plus4 <= i_pc_plus4;
         r_valid    <= 1'b1;
      end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC and fetch FSM driving instruction memory and the IF/ID register
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter logic [31:0] NOP      = NOP_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        StallF,
   input  logic        StallD,
   input  logic        PCSrcD,
   input  logic        JumpD,
   input  logic [31:0] PCBranchD,
   input  logic [31:0] PCJumpD,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] InstrD,
   output logic [31:0] PCPlus4D,
   output logic        ValidD,
   output logic        FetchStall
);
   logic [1:0]  r_state;
   logic [31:0] r_pcf, r_buf, r_drain_addr;
   logic        w_stall, w_redirect, w_load, w_bubble;
   logic        w_in_fetch, w_in_hold, w_in_drain;
   logic [1:0]  w_next;
   logic [31:0] w_target, w_pc_plus4, w_instr;
   assign w_stall    = StallF | StallD;
   assign w_in_fetch = r_state == FETCH;
   assign w_in_hold  = r_state == HOLD;
   assign w_in_drain = r_state == DRAIN;
   // DRAIN already owns the new target, so a second redirect there is ignored
   assign w_redirect = (PCSrcD | JumpD) & ValidD & ~w_stall & ~w_in_drain;
   assign w_target   = PCSrcD ? PCBranchD : PCJumpD;
   assign w_pc_plus4 = pc_plus4(r_pcf);
   assign w_instr    = w_in_hold ? r_buf : imem_rdata;
   assign imem_req   = ~rst & ~w_in_hold;
   assign imem_addr  = w_in_drain ? r_drain_addr : r_pcf;
   assign FetchStall = imem_req & ~imem_ack;
   assign w_load     = ~w_stall & ~w_redirect & ((w_in_fetch & imem_ack) | w_in_hold);
   assign w_bubble   = w_redirect | (~w_stall & ((w_in_fetch & ~imem_ack) | w_in_drain));
   // next state: a redirect with the request still open must drain it first
   always_comb
      w_next = w_in_fetch ? ((w_redirect & ~imem_ack) ? DRAIN : (imem_ack & w_stall) ? HOLD : FETCH) :
               w_in_hold  ? (w_stall ? HOLD : FETCH) :
               w_in_drain ? (imem_ack ? FETCH : DRAIN) : FETCH;
   // PC, FSM state, word parked under stall and address of the request being drained
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_state      <= FETCH;
         r_pcf        <= RESET_PC;
         r_buf        <= '0;
         r_drain_addr <= '0;
      end else begin
         if (w_redirect) r_pcf <= w_target;
         else if (w_load) r_pcf <= w_pc_plus4;
         if (w_in_fetch & imem_ack & w_stall) r_buf <= imem_rdata;
         if (w_in_fetch & w_redirect & ~imem_ack) r_drain_addr <= r_pcf;
         r_state <= w_next;
      end
   if_id_reg #(.NOP(NOP)) u_if_id (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_load),
      .i_bubble   (w_bubble),
      .i_instr    (w_instr),
      .i_pc_plus4 (w_pc_plus4),
      .o_instr    (InstrD),
      .o_pc_plus4 (PCPlus4D),
      .o_valid    (ValidD)
   );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: random stalls, branches and memory latency against an in-order fetch-stream scoreboard
module tb_fetch_stage;
   localparam logic [31:0] RPC  = 32'h0000_1000;
   localparam logic [31:0] NOPW = 32'h0000_0013;
   logic        clk = 1'b0, rst = 1'b1;
   logic        StallF = 1'b0, StallD = 1'b0, PCSrcD = 1'b0, JumpD = 1'b0;
   logic [31:0] PCBranchD = '0, PCJumpD = '0;
   logic        imem_req, imem_ack = 1'b0, ValidD, FetchStall;
   logic [31:0] imem_addr, imem_rdata, InstrD, PCPlus4D;
   int          errors = 0, checks = 0, deliveries = 0;
   logic        mon_en = 1'b0;
   logic [31:0] exp_q[$];

   fetch_stage #(.RESET_PC(RPC), .NOP(NOPW)) dut (
      .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .PCSrcD(PCSrcD), .JumpD(JumpD),
      .PCBranchD(PCBranchD), .PCJumpD(PCJumpD), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .InstrD(InstrD), .PCPlus4D(PCPlus4D),
      .ValidD(ValidD), .FetchStall(FetchStall)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
   endfunction

   assign imem_rdata = mem_word(imem_addr);

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, req, $time);
      end
   endtask

   // monitor: judges each clock edge from the inputs and outputs seen in the cycle before it
   logic        p_have = 1'b0, p_req, p_ack, p_stall, p_redir, p_valid;
   logic [31:0] p_addr, p_instr, p_pc4, e;
   initial forever begin
      @(negedge clk);
      if (rst || !mon_en) p_have = 1'b0;
      else begin
         check("fetch_stall", {31'd0, FetchStall}, {31'd0, imem_req & ~imem_ack});
         if (p_have) begin
            if (p_req && !p_ack) begin
               check("req_kept", {31'd0, imem_req}, 32'd1);
               check("addr_kept", imem_addr, p_addr);
            end
            if (p_redir) begin
               check("redir_bubble_valid", {31'd0, ValidD}, 32'd0);
               check("redir_bubble_pc4", PCPlus4D, p_pc4);
            end else if (p_stall) begin
               check("stall_instr", InstrD, p_instr);
               check("stall_pc4", PCPlus4D, p_pc4);
               check("stall_valid", {31'd0, ValidD}, {31'd0, p_valid});
            end else if (ValidD) begin
               deliveries++;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_delivery: got instr %h pc4 %h, expected none", InstrD, PCPlus4D);
               end else begin
                  e = exp_q.pop_front();
                  check("deliver_instr", InstrD, mem_word(e));
                  check("deliver_pc4", PCPlus4D, e + 32'd4);
                  exp_q.push_back(e + 32'd4);
               end
            end else begin
               check("bubble_instr", InstrD, NOPW);
               check("bubble_pc4", PCPlus4D, p_pc4);
            end
         end
         p_req   = imem_req;
         p_ack   = imem_ack;
         p_addr  = imem_addr;
         p_stall = StallF | StallD;
         p_redir = (PCSrcD | JumpD) & ValidD & ~(StallF | StallD);
         p_valid = ValidD;
         p_instr = InstrD;
         p_pc4   = PCPlus4D;
         p_have  = 1'b1;
      end
   end

   logic        redir, got;
   logic [31:0] tgt, old_addr;
   int          r;
   initial begin
      exp_q = {RPC};
      repeat (3) @(posedge clk);
      #1;
      check("rst_req", {31'd0, imem_req}, 32'd0);
      check("rst_valid", {31'd0, ValidD}, 32'd0);
      check("rst_instr", InstrD, NOPW);
      check("rst_pc4", PCPlus4D, 32'd0);
      rst = 1'b0;
      mon_en = 1'b1;
      #1;
      check("first_req", {31'd0, imem_req}, 32'd1);
      check("first_addr", imem_addr, RPC);
      for (int n = 0; n < 4000; n++) begin
         @(posedge clk);
         #1;
         StallF    = ($urandom_range(0, 7) == 0);
         StallD    = ($urandom_range(0, 9) == 0);
         r         = $urandom_range(0, 15);
         PCSrcD    = (r == 0) || (r == 2);
         JumpD     = (r == 1) || (r == 2);
         PCBranchD = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'h0003_FFFC);
         PCJumpD   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'h0003_FFFC);
         imem_ack  = imem_req && ($urandom_range(0, 9) < 6);
         redir     = (PCSrcD | JumpD) & ValidD & ~(StallF | StallD);
         tgt       = PCSrcD ? PCBranchD : PCJumpD;
         @(negedge clk);
         #1;
         if (redir) begin
            exp_q.delete();
            exp_q.push_back(tgt);
         end
      end
      check("progress", {31'd0, deliveries > 200}, 32'd1);
      // directed: reset while draining a redirected miss
      @(posedge clk);
      #1;
      mon_en = 1'b0;
      StallF = 1'b0;
      StallD = 1'b0;
      PCSrcD = 1'b0;
      JumpD  = 1'b0;
      got    = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         imem_ack = imem_req;
         @(posedge clk);
         #1;
         got = ValidD;
      end
      check("valid_before_drain", {31'd0, got}, 32'd1);
      imem_ack  = 1'b0;
      PCSrcD    = 1'b1;
      PCBranchD = 32'h0000_0100;
      old_addr  = imem_addr;
      @(posedge clk);
      #1;
      PCSrcD = 1'b0;
      check("drain_req", {31'd0, imem_req}, 32'd1);
      check("drain_addr", imem_addr, old_addr);
      check("drain_bubble", {31'd0, ValidD}, 32'd0);
      rst = 1'b1;
      #1;
      check("mid_rst_req", {31'd0, imem_req}, 32'd0);
      check("mid_rst_valid", {31'd0, ValidD}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("restart_req", {31'd0, imem_req}, 32'd1);
      check("restart_addr", imem_addr, RPC);
      imem_ack = 1'b1;
      @(posedge clk);
      #1;
      imem_ack = 1'b0;
      check("restart_valid", {31'd0, ValidD}, 32'd1);
      check("restart_instr", InstrD, mem_word(RPC));
      check("restart_pc4", PCPlus4D, RPC + 32'd4);
      check("restart_next_addr", imem_addr, RPC + 32'd4);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
